// File: rtl/printer_arbiter.sv
// Round-robin arbiter sharing one string printer among NUM_REQ requesters; request to printer_enable is 2 cycles when idle.
// One print outstanding at a time; repeat requests are dropped while pending and a watchdog aborts a hung print.
module printer_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int STR_ID_W = 2,
    parameter int TIMEOUT  = 1000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*STR_ID_W-1:0] req_str_id,
    output logic [NUM_REQ-1:0]          req_busy,
    output logic [NUM_REQ-1:0]          req_done,
    output logic                        printer_enable,
    output logic [STR_ID_W-1:0]         printer_str_id,
    input  logic                        printer_done,
    output logic                        printer_timeout,
    output logic                        busy
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int IW1   = IDX_W + 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    logic [NUM_REQ-1:0]  pending;
    logic [STR_ID_W-1:0] ids [NUM_REQ];
    logic [IDX_W-1:0]    grant;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    sel_idx;
    logic [CNT_W-1:0]    wd_cnt;
    logic                print_ok;
    logic                wd_fire;
    logic                finish;

    assign req_busy = pending;
    assign print_ok = (state == WAIT) && printer_done;
    assign wd_fire  = (TIMEOUT != 0) && (state == WAIT) && !printer_done && (wd_cnt == CNT_LAST);
    assign finish   = print_ok || wd_fire;

    // First pending index after last_grant, wrapping at NUM_REQ.
    always_comb begin
        logic [IW1-1:0] cand;
        logic           found;
        sel_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant} + IW1'(k);
            if (cand >= IW1'(NUM_REQ)) begin
                cand = cand - IW1'(NUM_REQ);
            end
            if (!found && pending[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            pending         <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                ids[i] <= '0;
            end
            grant           <= '0;
            last_grant      <= IDX_W'(NUM_REQ - 1);
            wd_cnt          <= '0;
            req_done        <= '0;
            printer_enable  <= 1'b0;
            printer_str_id  <= '0;
            printer_timeout <= 1'b0;
            busy            <= 1'b0;
        end else begin
            printer_enable  <= 1'b0;
            printer_timeout <= 1'b0;
            req_done        <= '0;

            // A new request landing on its own completion cycle re-arms the slot.
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && (!pending[i] || (finish && grant == IDX_W'(i)))) begin
                    pending[i] <= 1'b1;
                    ids[i]     <= req_str_id[i*STR_ID_W +: STR_ID_W];
                end else if (finish && grant == IDX_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end

            case (state)
                IDLE: begin
                    // Skip the cycle carrying a completion pulse so the printer gets a recovery gap.
                    if (|pending && !(|req_done)) begin
                        grant          <= sel_idx;
                        last_grant     <= sel_idx;
                        printer_str_id <= ids[sel_idx];
                        printer_enable <= 1'b1;
                        busy           <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (finish) begin
                        req_done[grant] <= 1'b1;
                        printer_timeout <= wd_fire;
                        busy            <= 1'b0;
                        state           <= IDLE;
                    end else if (wd_cnt != '1) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_printer_arbiter.sv
// Bench for printer_arbiter: vector table, directed corner sequences, then random traffic against a reference model.
module tb_printer_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_valid;
    logic [7:0] req_str_id;
    logic [3:0] req_busy;
    logic [3:0] req_done;
    logic       printer_enable;
    logic [1:0] printer_str_id;
    logic       printer_done;
    logic       printer_timeout;
    logic       busy;

    printer_arbiter #(.NUM_REQ(NREQ), .STR_ID_W(2), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_str_id(req_str_id),
        .req_busy(req_busy), .req_done(req_done), .printer_enable(printer_enable),
        .printer_str_id(printer_str_id), .printer_done(printer_done),
        .printer_timeout(printer_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int now = 0;
    int n_en = 0;
    int n_to = 0;
    int n_done [NREQ];

    // Reference model: requests as flags/IDs, the print in flight as an issue timestamp.
    logic [3:0] m_pend;
    logic [1:0] m_id [NREQ];
    logic [1:0] m_last;
    logic [1:0] m_grant;
    logic       m_inflight;
    int         m_t_issue;
    logic [1:0] e_str;
    logic [3:0] e_done;
    logic       e_en, e_to, e_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, now, act, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] v, input logic [7:0] ids, input logic pd, input logic r);
        logic [3:0] nd;
        logic       nen, nto, complete;
        logic [1:0] c;
        nd = '0; nen = 1'b0; nto = 1'b0; complete = 1'b0; c = '0;
        if (r) begin
            m_pend = '0;
            for (int i = 0; i < NREQ; i++) m_id[i] = '0;
            m_last = 2'(NREQ - 1);
            m_grant = '0; m_inflight = 1'b0; m_t_issue = 0;
            e_str = '0; e_done = '0; e_en = 1'b0; e_to = 1'b0; e_busy = 1'b0;
        end else begin
            if (!m_inflight) begin
                if (m_pend != 4'b0 && e_done == 4'b0) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        c = 2'((int'(m_last) + k) % NREQ);
                        if (m_pend[c] && !nen) begin
                            nen = 1'b1;
                            m_grant = c;
                        end
                    end
                    m_last = m_grant;
                    e_str = m_id[m_grant];
                    m_inflight = 1'b1;
                    m_t_issue = now + 1;
                end
            end else if (now > m_t_issue) begin
                if (pd) complete = 1'b1;
                else if (now - m_t_issue == TO) begin
                    complete = 1'b1;
                    nto = 1'b1;
                end
            end
            if (complete) begin
                nd[m_grant] = 1'b1;
                m_inflight = 1'b0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (v[i] && (!m_pend[i] || (complete && m_grant == 2'(i)))) begin
                    m_pend[i] = 1'b1;
                    m_id[i] = ids[2*i +: 2];
                end else if (complete && m_grant == 2'(i)) begin
                    m_pend[i] = 1'b0;
                end
            end
            e_en = nen; e_done = nd; e_to = nto; e_busy = m_inflight;
        end
        now++;
    endtask

    task automatic step(input logic [3:0] v, input logic [7:0] ids, input logic pd, input logic r);
        req_valid = v; req_str_id = ids; printer_done = pd; rst = r;
        @(posedge clk);
        model_step(v, ids, pd, r);
        #1;
        chk("m_req_busy", 32'(req_busy), 32'(m_pend));
        chk("m_req_done", 32'(req_done), 32'(e_done));
        chk("m_enable", 32'(printer_enable), 32'(e_en));
        chk("m_timeout", 32'(printer_timeout), 32'(e_to));
        chk("m_busy", 32'(busy), 32'(e_busy));
        chk("m_str_id", 32'(printer_str_id), 32'(e_str));
        if (printer_enable) n_en++;
        if (printer_timeout) n_to++;
        for (int i = 0; i < NREQ; i++) if (req_done[i]) n_done[i]++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic wait_enable(output logic [1:0] s);
        bit seen;
        seen = 0;
        s = '0;
        for (int k = 0; k < 30 && !seen; k++) begin
            step(4'b0, 8'h00, 1'b0, 1'b0);
            if (printer_enable) begin
                seen = 1;
                s = printer_str_id;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_enable cyc=%0d got=no_enable expected=enable_within_30", now);
        end
    endtask

    typedef struct packed {
        logic [3:0] v;
        logic [7:0] ids;
        logic       pd;
        logic       en;
        logic [1:0] str;
        logic       bsy;
        logic [3:0] rb;
        logic [3:0] dn;
        logic       to;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [1:0] s;
        logic [1:0] order [4];
        int en0, d0, to0, k;
        for (int i = 0; i < NREQ; i++) n_done[i] = 0;
        req_valid = '0; req_str_id = '0; printer_done = 1'b0; rst = 1'b1;

        // fields: v, ids, pd | en, str, busy, req_busy, req_done, timeout (expected one cycle later)
        tbl[0]  = '{4'b0001, 8'h02, 1'b0, 1'b0, 2'd0, 1'b0, 4'b0001, 4'b0000, 1'b0};
        tbl[1]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd2, 1'b1, 4'b0001, 4'b0000, 1'b0};
        tbl[2]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0001, 4'b0000, 1'b0};
        tbl[3]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1, 4'b0001, 4'b0000, 1'b0};
        tbl[4]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0001, 1'b0};
        tbl[5]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd2, 1'b0, 4'b0000, 4'b0000, 1'b0};
        tbl[6]  = '{4'b1010, 8'hC4, 1'b0, 1'b0, 2'd2, 1'b0, 4'b1010, 4'b0000, 1'b0};
        tbl[7]  = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd1, 1'b1, 4'b1010, 4'b0000, 1'b0};
        tbl[8]  = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd1, 1'b1, 4'b1010, 4'b0000, 1'b0};
        tbl[9]  = '{4'b0000, 8'h00, 1'b1, 1'b0, 2'd1, 1'b0, 4'b1000, 4'b0010, 1'b0};
        tbl[10] = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd1, 1'b0, 4'b1000, 4'b0000, 1'b0};
        tbl[11] = '{4'b0000, 8'h00, 1'b0, 1'b1, 2'd3, 1'b1, 4'b1000, 4'b0000, 1'b0};
        tbl[12] = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd3, 1'b1, 4'b1000, 4'b0000, 1'b0};
        tbl[13] = '{4'b0000, 8'h00, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000, 4'b1000, 1'b0};
        tbl[14] = '{4'b0000, 8'h00, 1'b0, 1'b0, 2'd3, 1'b0, 4'b0000, 4'b0000, 1'b0};

        // Reset state
        step(4'b0, 8'h00, 1'b0, 1'b1);
        step(4'b0, 8'h00, 1'b0, 1'b1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_busy", 32'(req_busy), 32'd0);
        chk("rst_req_done", 32'(req_done), 32'd0);
        chk("rst_enable", 32'(printer_enable), 32'd0);
        chk("rst_timeout", 32'(printer_timeout), 32'd0);
        chk("rst_str_id", 32'(printer_str_id), 32'd0);
        idle(3);

        // Vector table: single request, then two simultaneous requests served 1 then 3
        for (int i = 0; i < 15; i++) begin
            step(tbl[i].v, tbl[i].ids, tbl[i].pd, 1'b0);
            chk($sformatf("tbl%0d_en", i), 32'(printer_enable), 32'(tbl[i].en));
            chk($sformatf("tbl%0d_str", i), 32'(printer_str_id), 32'(tbl[i].str));
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("tbl%0d_req_busy", i), 32'(req_busy), 32'(tbl[i].rb));
            chk($sformatf("tbl%0d_req_done", i), 32'(req_done), 32'(tbl[i].dn));
            chk($sformatf("tbl%0d_timeout", i), 32'(printer_timeout), 32'(tbl[i].to));
        end

        // Round-robin order 2,3,0,1 with last_grant=1 and all four pending
        step(4'b0010, 8'h04, 1'b0, 1'b0);
        wait_enable(s);
        step(4'b0, 8'h00, 1'b0, 1'b0);
        step(4'b0, 8'h00, 1'b1, 1'b0);
        step(4'b1111, 8'hE4, 1'b0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            wait_enable(order[j]);
            step(4'b0, 8'h00, 1'b0, 1'b0);
            step(4'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("rr_order0", 32'(order[0]), 32'd2);
        chk("rr_order1", 32'(order[1]), 32'd3);
        chk("rr_order2", 32'(order[2]), 32'd0);
        chk("rr_order3", 32'(order[3]), 32'd1);
        idle(2);

        // Repeat request while in service is dropped
        en0 = n_en; d0 = n_done[0];
        step(4'b0001, 8'h01, 1'b0, 1'b0);
        wait_enable(s);
        chk("dup_str", 32'(s), 32'd1);
        step(4'b0, 8'h00, 1'b0, 1'b0);
        step(4'b0001, 8'h03, 1'b0, 1'b0);
        step(4'b0, 8'h00, 1'b0, 1'b0);
        step(4'b0, 8'h00, 1'b1, 1'b0);
        idle(6);
        chk("dup_enables", 32'(n_en - en0), 32'd1);
        chk("dup_dones", 32'(n_done[0] - d0), 32'd1);
        chk("dup_req_busy", 32'(req_busy), 32'd0);

        // New request on the completion cycle re-arms with the new ID
        step(4'b0100, 8'h10, 1'b0, 1'b0);
        wait_enable(s);
        chk("rearm_str1", 32'(s), 32'd1);
        step(4'b0, 8'h00, 1'b0, 1'b0);
        step(4'b0100, 8'h30, 1'b1, 1'b0);
        chk("rearm_done", 32'(req_done), 32'b0100);
        chk("rearm_busy2", 32'(req_busy[2]), 32'd1);
        chk("rearm_str_hold", 32'(printer_str_id), 32'd1);
        wait_enable(s);
        chk("rearm_str2", 32'(s), 32'd3);
        step(4'b0, 8'h00, 1'b0, 1'b0);
        step(4'b0, 8'h00, 1'b1, 1'b0);
        chk("rearm_done2", 32'(req_done), 32'b0100);
        idle(2);

        // Watchdog: 8 cycles after entering WAIT, then next requester served
        to0 = n_to;
        step(4'b1001, 8'h42, 1'b0, 1'b0);
        wait_enable(s);
        chk("wd_first_str", 32'(s), 32'd1);
        k = 0;
        for (int j = 1; j <= 12 && k == 0; j++) begin
            step(4'b0, 8'h00, 1'b0, 1'b0);
            if (printer_timeout) begin
                k = j;
                chk("wd_done_with_to", 32'(req_done), 32'b1000);
            end
        end
        chk("wd_cycles", 32'(k), 32'd9);
        chk("wd_pulses", 32'(n_to - to0), 32'd1);
        wait_enable(s);
        chk("wd_next_str", 32'(s), 32'd2);
        idle(8);
        step(4'b0, 8'h00, 1'b1, 1'b0);
        chk("wd_tie_timeout", 32'(printer_timeout), 32'd0);
        chk("wd_tie_done", 32'(req_done), 32'b0001);
        idle(2);

        // Reset in the middle of WAIT
        step(4'b0100, 8'h30, 1'b0, 1'b0);
        wait_enable(s);
        step(4'b0, 8'h00, 1'b0, 1'b0);
        step(4'b0, 8'h00, 1'b0, 1'b0);
        step(4'b0, 8'h00, 1'b0, 1'b1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_req_busy", 32'(req_busy), 32'd0);
        chk("mid_rst_req_done", 32'(req_done), 32'd0);
        chk("mid_rst_enable", 32'(printer_enable), 32'd0);
        en0 = n_en; d0 = n_done[2];
        idle(5);
        chk("mid_rst_no_enable", 32'(n_en - en0), 32'd0);
        chk("mid_rst_no_done", 32'(n_done[2] - d0), 32'd0);
        step(4'b1001, 8'h42, 1'b0, 1'b0);
        wait_enable(s);
        chk("mid_rst_prio0", 32'(s), 32'd2);
        step(4'b0, 8'h00, 1'b0, 1'b0);
        step(4'b0, 8'h00, 1'b1, 1'b0);
        idle(2);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] v;
            for (int i = 0; i < NREQ; i++) v[i] = ($urandom_range(0, 5) == 0);
            step(v, 8'($urandom_range(0, 255)), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 799) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
